// File: rtl/demux_seq_pkg.sv
// ---------------------------------------------------------------------------
// demux_seq_pkg
//   Shared types and constants for the 1:8 de-mux feeder (demux_sel_sequencer).
//   seq_state_t : sequencer FSM states (IDLE, SHIFT, DONE)
//   DEMUX_CH    : channel count of the downstream de-mux
//   DEMUX_SEL_W : select width matching DEMUX_CH
// ---------------------------------------------------------------------------
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int DEMUX_CH    = 8;
    localparam int DEMUX_SEL_W = 3;

endpackage : demux_seq_pkg

// File: rtl/demux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// demux_sel_sequencer
//   Upstream feeder for the 1:8 de-mux. Takes one NUM_CH-bit word per
//   valid/ready handshake and serialises it onto demux_in while walking sel
//   across every channel, so bit i of the word lands on de-mux output i.
//   Pulses frame_done for one cycle once the last channel has been driven.
//   Connects to demux_1to8 as: sel -> sel, demux_in -> in.
//
// Configuration macro:
//   DEMUX_SEQ_MSB_FIRST_EN  defined   : channels driven NUM_CH-1 down to 0
//                           undefined : channels driven 0 up to NUM_CH-1
//   Handshake, latency and frame_done timing are the same in both builds.
//
// Ports:
//   clk          in   1       single clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   data_in      in   NUM_CH  word to serialise
//   data_valid   in   1       data_in valid
//   data_ready   out  1       word can be accepted (IDLE only, low in reset)
//   step_en      in   1       downstream may take a bit this cycle; low = stall
//   sel          out  SEL_W   de-mux select (registered)
//   demux_in     out  1       de-mux serial input (IDLE_LEVEL when not valid)
//   demux_valid  out  1       sel/demux_in carry a real bit this cycle
//   frame_done   out  1       one-cycle pulse: word fully delivered
//   busy         out  1       high in SHIFT or DONE
// ---------------------------------------------------------------------------
module demux_sel_sequencer
    import demux_seq_pkg::*;
#(
    parameter int   NUM_CH     = DEMUX_CH,
    parameter int   SEL_W      = $clog2(NUM_CH),
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              step_en,
    output logic [SEL_W-1:0]  sel,
    output logic              demux_in,
    output logic              demux_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(NUM_CH - 1);

    seq_state_t        state, state_nx;
    logic [SEL_W-1:0]  cnt;
    logic [SEL_W-1:0]  cnt_inc;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] word;
    logic              accept;

    // Map the bit counter onto a channel index; the counter itself always
    // runs upward so the DONE decision is identical in both builds.
    function automatic logic [SEL_W-1:0] idx_of(input logic [SEL_W-1:0] c);
`ifdef DEMUX_SEQ_MSB_FIRST_EN
        return LAST_CNT - c;
`else
        return c;
`endif
    endfunction

    assign cnt_inc = cnt + SEL_W'(1);
    assign accept  = (state == IDLE) && data_valid && !rst;
    assign sel     = sel_q;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode.
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        data_ready  = 1'b0;
        demux_valid = 1'b0;
        demux_in    = IDLE_LEVEL;
        frame_done  = 1'b0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                // Gated by rst so the handshake is closed while in reset.
                data_ready = !rst;
                if (accept) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy        = 1'b1;
                demux_valid = step_en;
                if (step_en) begin
                    demux_in = word[idx_of(cnt)];
                    if (cnt == LAST_CNT) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: word capture, bit counter and registered select.
    // sel_q is loaded one edge ahead so it already equals idx_of(cnt) in the
    // cycle that uses it, and drops back to 0 once the last bit is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            cnt   <= '0;
            sel_q <= '0;
        end else if (accept) begin
            word  <= data_in;
            cnt   <= '0;
            sel_q <= idx_of('0);
        end else if ((state == SHIFT) && step_en) begin
            if (cnt == LAST_CNT) begin
                cnt   <= '0;
                sel_q <= '0;
            end else begin
                cnt   <= cnt_inc;
                sel_q <= idx_of(cnt_inc);
            end
        end
    end

endmodule : demux_sel_sequencer
